// File: rtl/div_secuencial_param.sv
// div_secuencial_param: sequential radix-2 restoring divider, signed/unsigned, with zero-divisor and overflow flags
module div_secuencial_param #(
    parameter int ANCHO = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             comenzar,
    input  logic             con_signo,
    input  logic [ANCHO-1:0] dividendo,
    input  logic [ANCHO-1:0] divisor,
    output logic [ANCHO-1:0] cociente,
    output logic [ANCHO-1:0] residuo,
    output logic             div_cero,
    output logic             desborde,
    output logic             ocupado,
    output logic             finalizado
);
    localparam int CW = $clog2(ANCHO);
    typedef enum logic [1:0] {REPOSO, ITERA, AJUSTE} estado_t;
    estado_t          estado;
    logic [CW-1:0]    cnt;
    logic [ANCHO-1:0] p, a, b, dvd, mag_dvd, mag_dvs, q_fin, r_fin;
    logic [ANCHO:0]   p_sh, prueba;
    logic             sq, sr, cero, ovf;

    // trial subtraction, operand magnitudes and sign/exception-adjusted results
    always_comb begin
        p_sh    = {p, a[ANCHO-1]};
        prueba  = p_sh - {1'b0, b};
        mag_dvd = (con_signo && dividendo[ANCHO-1]) ? -dividendo : dividendo;
        mag_dvs = (con_signo && divisor[ANCHO-1]) ? -divisor : divisor;
        q_fin   = cero ? '1 : ovf ? {1'b0, {(ANCHO-1){1'b1}}} : sq ? -a : a;
        r_fin   = cero ? dvd : ovf ? '0 : sr ? -p : p;
    end

    // control FSM: capture, one quotient bit per cycle (dividend shifts out as quotient shifts in), then adjust
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            estado     <= REPOSO;
            cnt        <= '0;
            p          <= '0;
            a          <= '0;
            b          <= '0;
            dvd        <= '0;
            sq         <= 1'b0;
            sr         <= 1'b0;
            cero       <= 1'b0;
            ovf        <= 1'b0;
            cociente   <= '0;
            residuo    <= '0;
            div_cero   <= 1'b0;
            desborde   <= 1'b0;
            ocupado    <= 1'b0;
            finalizado <= 1'b0;
        end else begin
            finalizado <= 1'b0;
            case (estado)
                REPOSO: if (comenzar) begin
                    p       <= '0;
                    a       <= mag_dvd;
                    b       <= mag_dvs;
                    dvd     <= dividendo;
                    cnt     <= '0;
                    sq      <= con_signo && (dividendo[ANCHO-1] ^ divisor[ANCHO-1]);
                    sr      <= con_signo && dividendo[ANCHO-1];
                    cero    <= divisor == '0;
                    ovf     <= con_signo && dividendo == {1'b1, {(ANCHO-1){1'b0}}} && &divisor;
                    ocupado <= 1'b1;
                    estado  <= (divisor == '0) ? AJUSTE : ITERA;
                end
                ITERA: begin
                    p   <= prueba[ANCHO] ? p_sh[ANCHO-1:0] : prueba[ANCHO-1:0];
                    a   <= {a[ANCHO-2:0], ~prueba[ANCHO]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ANCHO - 1))
                        estado <= AJUSTE;
                end
                AJUSTE: begin
                    cociente   <= q_fin;
                    residuo    <= r_fin;
                    div_cero   <= cero;
                    desborde   <= ovf;
                    ocupado    <= 1'b0;
                    finalizado <= 1'b1;
                    estado     <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_div_secuencial_param.sv
// tb_div_secuencial_param: directed and random checks of the sequential divider at widths 16 and 8
module tb_div_secuencial_param;
    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        c16 = 1'b0, s16 = 1'b0, c8 = 1'b0, s8 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0, q16o, r16o;
    logic [7:0]  x8 = '0, y8 = '0, q8o, r8o;
    logic        z16, o16, oc16, f16, z8, o8, oc8, f8;
    logic [33:0] sb16[$];
    logic [17:0] sb8[$];
    int          pasados = 0, total = 0, ciclo = 0, fins16 = 0, fins8 = 0, e0_16 = 0, e0_8 = 0, f0 = 0;

    div_secuencial_param #(.ANCHO(16)) dut16 (
        .clock(clock), .rst(rst), .comenzar(c16), .con_signo(s16), .dividendo(x16), .divisor(y16),
        .cociente(q16o), .residuo(r16o), .div_cero(z16), .desborde(o16), .ocupado(oc16), .finalizado(f16)
    );

    div_secuencial_param #(.ANCHO(8)) dut8 (
        .clock(clock), .rst(rst), .comenzar(c8), .con_signo(s8), .dividendo(x8), .divisor(y8),
        .cociente(q8o), .residuo(r8o), .div_cero(z8), .desborde(o8), .ocupado(oc8), .finalizado(f8)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        total++;
        assert (obs === esp) pasados++;
        else $error("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    endtask

    // reference: {div_cero, desborde, cociente[31:0], residuo[31:0]} from integer arithmetic
    function automatic logic [65:0] modelo(input int w, input bit s, input logic [31:0] x, input logic [31:0] y);
        longint mask, sx, sy, q, r;
        logic z, o;
        mask = (longint'(1) << w) - 1;
        sx = longint'(x);
        sy = longint'(y);
        z = 1'b0;
        o = 1'b0;
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        if (y == 0) begin
            z = 1'b1; q = mask; r = longint'(x);
        end else if (s && sx == -(longint'(1) << (w - 1)) && sy == -1) begin
            o = 1'b1; q = mask >> 1; r = 0;
        end else begin
            q = (sx / sy) & mask; r = (sx % sy) & mask;
        end
        return {z, o, q[31:0], r[31:0]};
    endfunction

    // scoreboard: every finalizado pops the oldest expectation
    always @(negedge clock) begin
        if (f16) begin
            fins16 <= fins16 + 1;
            chk("cola16", 64'(sb16.size() != 0), 64'(1));
            if (sb16.size() != 0) chk("res16", 64'({z16, o16, q16o, r16o}), 64'(sb16.pop_front()));
        end
        if (f8) begin
            fins8 <= fins8 + 1;
            chk("cola8", 64'(sb8.size() != 0), 64'(1));
            if (sb8.size() != 0) chk("res8", 64'({z8, o8, q8o, r8o}), 64'(sb8.pop_front()));
        end
    end

    // called at a negedge; comenzar stays high for dur cycles
    task automatic arranque(input bit ocho, input bit s, input logic [15:0] x, input logic [15:0] y, input int dur);
        logic [65:0] m;
        if (ocho) begin
            m = modelo(8, s, {24'b0, x[7:0]}, {24'b0, y[7:0]});
            sb8.push_back({m[65:64], m[39:32], m[7:0]});
            s8 = s; x8 = x[7:0]; y8 = y[7:0]; c8 = 1'b1; e0_8 = ciclo + 1;
        end else begin
            m = modelo(16, s, {16'b0, x}, {16'b0, y});
            sb16.push_back({m[65:64], m[47:32], m[15:0]});
            s16 = s; x16 = x; y16 = y; c16 = 1'b1; e0_16 = ciclo + 1;
        end
        repeat (dur) @(negedge clock);
        c8 = 1'b0;
        c16 = 1'b0;
    endtask

    // waits (bounded) for finalizado and checks the edge count from the start edge
    task automatic espera(input bit ocho, input int lat, input string tag);
        int n = 0;
        while (!(ocho ? f8 : f16) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_fin"}, 64'(ocho ? f8 : f16), 64'(1));
        chk({tag, "_lat"}, 64'(ciclo - (ocho ? e0_8 : e0_16)), 64'(lat));
    endtask

    initial begin
        logic [15:0] rx, ry;
        bit rs;
        #3;
        chk("reset16", 64'({q16o, r16o, z16, o16, oc16, f16}), 64'(0));
        chk("reset8", 64'({q8o, r8o, z8, o8, oc8, f8}), 64'(0));
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        // unsigned nominal with a two-cycle comenzar
        f0 = fins16;
        arranque(0, 0, 16'h03E8, 16'h0019, 2);
        chk("nom_ocupado", 64'(oc16), 64'(1));
        espera(0, 17, "nom");
        chk("nom_q", 64'(q16o), 64'(16'h0028));
        chk("nom_r", 64'(r16o), 64'(0));
        chk("nom_ocupado_fin", 64'(oc16), 64'(0));
        repeat (25) @(negedge clock);
        chk("nom_pulsos", 64'(fins16 - f0), 64'(1));
        chk("nom_estable", 64'(q16o), 64'(16'h0028));
        // signed truncation
        arranque(0, 1, 16'hFFF9, 16'h0002, 1);
        espera(0, 17, "neg7");
        chk("neg7_qr", 64'({q16o, r16o}), 64'(32'hFFFD_FFFF));
        @(negedge clock);
        arranque(0, 1, 16'h0007, 16'hFFFE, 1);
        espera(0, 17, "pos7");
        chk("pos7_qr", 64'({q16o, r16o}), 64'(32'hFFFD_0001));
        @(negedge clock);
        // divide by zero, both modes, then flag clears
        arranque(0, 0, 16'h03E8, 16'h0000, 1);
        espera(0, 1, "cero_u");
        chk("cero_u", 64'({z16, o16, q16o, r16o}), 64'({2'b10, 16'hFFFF, 16'h03E8}));
        @(negedge clock);
        arranque(0, 1, 16'h03E8, 16'h0000, 1);
        espera(0, 1, "cero_s");
        chk("cero_s", 64'({z16, o16, q16o, r16o}), 64'({2'b10, 16'hFFFF, 16'h03E8}));
        @(negedge clock);
        arranque(0, 0, 16'h0010, 16'h0004, 1);
        espera(0, 17, "tras_cero");
        chk("tras_cero", 64'({z16, q16o}), 64'({1'b0, 16'h0004}));
        @(negedge clock);
        // signed overflow vs unsigned
        arranque(0, 1, 16'h8000, 16'hFFFF, 1);
        espera(0, 17, "ovf_s");
        chk("ovf_s", 64'({z16, o16, q16o, r16o}), 64'({2'b01, 16'h7FFF, 16'h0000}));
        @(negedge clock);
        arranque(0, 0, 16'h8000, 16'hFFFF, 1);
        espera(0, 17, "ovf_u");
        chk("ovf_u", 64'({z16, o16, q16o, r16o}), 64'({2'b00, 16'h0000, 16'h8000}));
        @(negedge clock);
        // reset in the middle of an operation
        arranque(0, 0, 16'h1234, 16'h0007, 1);
        repeat (7) @(negedge clock);
        f0 = fins16;
        #2 rst = 1'b0;
        #1 chk("rst_medio", 64'({q16o, r16o, z16, o16, oc16, f16}), 64'(0));
        void'(sb16.pop_back());
        @(negedge clock);
        rst = 1'b1;
        repeat (30) @(negedge clock);
        chk("rst_sin_fin", 64'(fins16 - f0), 64'(0));
        arranque(0, 0, 16'h1234, 16'h0007, 1);
        espera(0, 17, "rst_reinicio");
        chk("rst_reinicio_q", 64'(q16o), 64'(16'h0299));
        @(negedge clock);
        // comenzar and operand changes while busy are ignored
        arranque(0, 0, 16'h1000, 16'h0003, 1);
        repeat (4) @(negedge clock);
        c16 = 1'b1; s16 = 1'b1; x16 = 16'hFFFF; y16 = 16'h0001;
        @(negedge clock);
        c16 = 1'b0;
        espera(0, 17, "ocupado");
        chk("ocupado_qr", 64'({q16o, r16o}), 64'(32'h0555_0001));
        @(negedge clock);
        // back-to-back start during the finalizado cycle
        f0 = fins16;
        arranque(0, 1, 16'hFF00, 16'h0010, 1);
        espera(0, 17, "b2b_a");
        arranque(0, 0, 16'h00FF, 16'h0010, 1);
        espera(0, 17, "b2b_b");
        chk("b2b_qr", 64'({q16o, r16o}), 64'(32'h000F_000F));
        @(negedge clock);
        chk("b2b_pulsos", 64'(fins16 - f0), 64'(2));
        // random sweeps at both widths
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1000; i++) begin
                rs = 1'($urandom);
                rx = 16'($urandom);
                ry = 16'($urandom);
                case ($urandom_range(0, 15))
                    0: ry = '0;
                    1: begin rs = 1'b1; rx = (w == 1) ? 16'h0080 : 16'h8000; ry = 16'hFFFF; end
                    2: ry = 16'($urandom_range(1, 5));
                    default: ;
                endcase
                if (w == 1) begin rx[15:8] = '0; ry[15:8] = '0; end
                arranque(w == 1, rs, rx, ry, 1);
                espera(w == 1, (ry == 0) ? 1 : ((w == 1) ? 9 : 17), (w == 1) ? "rnd8" : "rnd16");
                @(negedge clock);
            end
        end
        repeat (5) @(negedge clock);
        chk("cola16_vacia", 64'(sb16.size()), 64'(0));
        chk("cola8_vacia", 64'(sb8.size()), 64'(0));
        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end
endmodule
